dmem_responder: RTL and testbench

- Memory-side responder for the CPU's load/store port. The CPU is the initiator; this block answers its requests.
- Accepts one request at a time through a valid/ready handshake and translates the CPU byte address against the data-segment base.
- Stores/loads byte, halfword or word with a configurable wait-state count, then returns data plus an error flag.
- Replaces the zero-latency data memory when the multi-cycle CPU variant is built.

---
 rtl/dmem_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side responder for the CPU load/store port. It accepts one request
// at a time over a valid/ready handshake and rebases the CPU byte address
// against BASE_ADDR. It then waits WAIT_CYCLES cycles, performs the byte,
// halfword or word access on an internal word array, and answers with a
// one-cycle response strobe.
//
// Ports:
//   clk_in      - clock, all state changes on the rising edge
//   reset       - synchronous, active-high
//   req_valid   - request present
//   req_ready   - request can be accepted (IDLE and reset low)
//   req_we      - 1 = store, 0 = load
//   req_size    - 00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed  - loads only: sign-extend (1) or zero-extend (0)
//   req_addr    - CPU byte address
//   req_wdata   - right-justified store data
//   resp_valid  - one-cycle response strobe
//   resp_rdata  - load result, 0 for stores and errors
//   resp_err    - request rejected (bad address, size or alignment)
module dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h10010000,
   parameter int          DEPTH_WORDS = 2048,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [3:0]  wait_cnt;

   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_signed;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        eff_we;
   logic [1:0]  eff_size;
   logic        eff_signed;
   logic [31:0] eff_addr;
   logic [31:0] eff_wdata;

   logic [31:0]      offset;
   logic [1:0]       lane;
   logic [IDX_W-1:0] word_idx;
   logic             req_bad;
   logic             enter_resp;
   logic             accept;
   logic             mem_write;
   logic [3:0]       byte_en;
   logic [31:0]      store_data;
   logic [31:0]      rd_word;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_data;

   logic [31:0] mem [DEPTH_WORDS];

   assign req_ready  = (state == ST_IDLE) && !reset;
   assign resp_valid = (state == ST_RESP);
   assign accept     = (state == ST_IDLE) && req_valid && !reset;

   // Next-state logic. With zero wait states an accepted request goes
   // straight to RESP, skipping WAIT entirely.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               next_state = ST_RESP;
            end
         end
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // The array access happens on the edge that enters RESP. When there are no
   // wait states, that edge is also the acceptance edge, so the live request
   // inputs must be used instead of the latched copy.
   always_comb begin
      if (state == ST_IDLE) begin
         eff_we     = req_we;
         eff_size   = req_size;
         eff_signed = req_signed;
         eff_addr   = req_addr;
         eff_wdata  = req_wdata;
      end else begin
         eff_we     = lat_we;
         eff_size   = lat_size;
         eff_signed = lat_signed;
         eff_addr   = lat_addr;
         eff_wdata  = lat_wdata;
      end
   end

   assign enter_resp = !reset && (next_state == ST_RESP) && (state != ST_RESP);
   assign offset     = eff_addr - BASE_ADDR;
   assign lane       = offset[1:0];
   assign word_idx   = offset[IDX_W+1:2];

   // A request is rejected if it falls outside the window, uses the
   // reserved size code, or is misaligned for its size.
   always_comb begin
      req_bad = (eff_addr < BASE_ADDR) || (offset >= SPAN_BYTES);
      case (eff_size)
         2'b00:   req_bad = req_bad;
         2'b01:   req_bad = req_bad || offset[0];
         2'b10:   req_bad = req_bad || (offset[1:0] != 2'b00);
         default: req_bad = 1'b1;
      endcase
   end

   // Store data is replicated across lanes so that the byte enables
   // alone decide which bytes of the word change.
   always_comb begin
      byte_en    = 4'b1111;
      store_data = eff_wdata;
      case (eff_size)
         2'b00: begin
            byte_en    = 4'b0001 << lane;
            store_data = {4{eff_wdata[7:0]}};
         end
         2'b01: begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {2{eff_wdata[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            store_data = eff_wdata;
         end
      endcase
   end

   // Load path: pick the addressed lane, move it to bit 0, then extend it.
   always_comb begin
      rd_word  = mem[word_idx];
      byte_sel = rd_word[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (eff_size)
         2'b00:   load_data = eff_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
         2'b01:   load_data = eff_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
         default: load_data = rd_word;
      endcase
   end

   assign mem_write = enter_resp && eff_we && !req_bad;

   // The array has no reset, so its contents survive a reset pulse.
   always_ff @(posedge clk_in) begin
      if (mem_write) begin
         for (int n = 0; n < 4; n++) begin
            if (byte_en[n]) begin
               mem[word_idx][8*n +: 8] <= store_data[8*n +: 8];
            end
         end
      end
   end

   // Control state, wait counter, request latch and registered response.
   // The request copy is not reset; it is only consulted after an acceptance.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state      <= ST_IDLE;
         wait_cnt   <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
         end
         if ((state == ST_IDLE) && (next_state == ST_WAIT)) begin
            wait_cnt <= WAIT_INIT;
         end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_err   <= req_bad;
            resp_rdata <= (req_bad || eff_we) ? 32'd0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder. The main instance uses two wait
// states and is checked against a byte-addressed reference memory. A second
// instance has no wait states and is used for the back-to-back timing case.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h10010000;
   localparam int          DEPTH = 2048;
   localparam int          W     = 2;

   logic        clk;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        z_valid, z_ready, z_we, z_signed;
   logic [1:0]  z_size;
   logic [31:0] z_addr, z_wdata;
   logic        z_resp_valid, z_err;
   logic [31:0] z_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ref_mem [int unsigned];

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk_in(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk_in(clk), .reset(reset),
      .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
      .req_size(z_size), .req_signed(z_signed), .req_addr(z_addr),
      .req_wdata(z_wdata), .resp_valid(z_resp_valid), .resp_rdata(z_rdata),
      .resp_err(z_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference memory: a byte-addressed map. The return value is 0 when a
   // load touches a byte never written, because its value is then unknown.
   function automatic bit modelAccess(input bit we, input logic [1:0] size, input bit sgn,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output bit err, output logic [31:0] rdata);
      int unsigned   off;
      int unsigned   nbytes;
      longint unsigned val;
      off    = addr - BASE;
      nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      err    = (addr < BASE) || (off >= 4 * DEPTH) || (size == 2'b11) || ((off % nbytes) != 0);
      rdata  = 32'd0;
      if (err) return 1'b1;
      if (we) begin
         for (int i = 0; i < nbytes; i++) ref_mem[off + i] = wdata[8*i +: 8];
         return 1'b1;
      end
      val = 0;
      for (int i = 0; i < nbytes; i++) begin
         if (!ref_mem.exists(off + i)) return 1'b0;
         val = val | (longint'(ref_mem[off + i]) << (8 * i));
      end
      if (sgn && (nbytes < 4) && (val >= (longint'(1) << (8 * nbytes - 1))))
         val = val - (longint'(1) << (8 * nbytes));
      rdata = 32'(val);
      return 1'b1;
   endfunction

   // One full handshake on the main instance, with timing checks on the
   // ready/valid behaviour around it.
   task automatic applyStimulus(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
      int waited;
      int lat;
      bit ready_seen;
      @(negedge clk);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "_accept"}, req_ready, 1);
      if (!req_ready) begin
         req_valid = 1'b0;
         rdata = 32'd0;
         err = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      ready_seen = req_ready;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
         if (req_ready) ready_seen = 1'b1;
      end
      rdata = resp_rdata;
      err   = resp_err;
      checkOutput({tag, "_latency"}, lat, W + 1);
      checkOutput({tag, "_ready_low"}, ready_seen, 0);
      @(negedge clk);
      checkOutput({tag, "_single_pulse"}, resp_valid, 0);
      checkOutput({tag, "_ready_back"}, req_ready, 1);
   endtask

   task automatic runAndCheck(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                              input logic [31:0] addr, input logic [31:0] wdata);
      bit          exp_err;
      logic [31:0] exp_rd;
      logic [31:0] got_rd;
      logic        got_err;
      bit          known;
      known = modelAccess(we, size, sgn, addr, wdata, exp_err, exp_rd);
      applyStimulus(tag, we, size, sgn, addr, wdata, got_rd, got_err);
      checkOutput({tag, "_err"}, got_err, exp_err);
      if (known) checkOutput({tag, "_rdata"}, got_rd, exp_rd);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [1:0]  z_sz [4] = '{2'b10, 2'b10, 2'b00, 2'b10};
   logic        z_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] z_ad [4] = '{32'h10010000, 32'h10010000, 32'h10010001, 32'h10010000};
   logic [31:0] z_wd [4] = '{32'hCAFEF00D, 32'h0, 32'h00000077, 32'h0};
   logic [31:0] z_ex [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFE770D};

   initial begin
      logic [31:0] win;
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;
      int          k;
      bit          saw;

      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0;
      z_valid = 1'b0; z_we = 1'b0; z_size = 2'b00; z_signed = 1'b0;
      z_addr = 32'd0; z_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_resp_valid", resp_valid, 0);
      checkOutput("reset_rdata", resp_rdata, 0);
      checkOutput("reset_err", resp_err, 0);
      checkOutput("reset_ready_low", req_ready, 0);
      checkOutput("reset_w0_ready_low", z_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", req_ready, 1);

      // Word store and load-back.
      runAndCheck("sw_deadbeef", 1'b1, 2'b10, 1'b0, BASE, 32'hDEADBEEF);
      runAndCheck("lw_deadbeef", 1'b0, 2'b10, 1'b0, BASE, 32'h0);

      // Byte store into an existing word, then byte/word loads.
      runAndCheck("sw_11223344", 1'b1, 2'b10, 1'b0, BASE, 32'h11223344);
      runAndCheck("sb_a5", 1'b1, 2'b00, 1'b0, BASE + 1, 32'h000000A5);
      runAndCheck("lw_after_sb", 1'b0, 2'b10, 1'b0, BASE, 32'h0);
      runAndCheck("lb_signed", 1'b0, 2'b00, 1'b1, BASE + 1, 32'h0);
      runAndCheck("lbu", 1'b0, 2'b00, 1'b0, BASE + 1, 32'h0);

      // Upper-half store, signed/unsigned half loads, low half preserved.
      runAndCheck("sw_55667788", 1'b1, 2'b10, 1'b0, BASE + 4, 32'h55667788);
      runAndCheck("sh_8001", 1'b1, 2'b01, 1'b0, BASE + 6, 32'h00008001);
      runAndCheck("lh_signed", 1'b0, 2'b01, 1'b1, BASE + 6, 32'h0);
      runAndCheck("lhu", 1'b0, 2'b01, 1'b0, BASE + 6, 32'h0);
      runAndCheck("lw_after_sh", 1'b0, 2'b10, 1'b0, BASE + 4, 32'h0);

      // Rejected requests, then confirm the memory did not change.
      runAndCheck("err_lw_misaligned", 1'b0, 2'b10, 1'b0, BASE + 2, 32'h0);
      runAndCheck("err_lh_misaligned", 1'b0, 2'b01, 1'b1, BASE + 3, 32'h0);
      runAndCheck("err_lw_below", 1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'h0);
      runAndCheck("err_sw_above", 1'b1, 2'b10, 1'b0, 32'h10012000, 32'h01020304);
      runAndCheck("err_size3_load", 1'b0, 2'b11, 1'b0, BASE, 32'h0);
      runAndCheck("err_size3_store", 1'b1, 2'b11, 1'b0, BASE, 32'hFFFFFFFF);
      runAndCheck("err_sw_misaligned", 1'b1, 2'b10, 1'b0, BASE + 1, 32'hFFFFFFFF);
      runAndCheck("lw_after_errs", 1'b0, 2'b10, 1'b0, BASE, 32'h0);
      runAndCheck("lw_after_errs4", 1'b0, 2'b10, 1'b0, BASE + 4, 32'h0);

      // Reset arrives on the edge that would have entered RESP for a store.
      runAndCheck("sw_prior", 1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'hAAAA5555);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = BASE + 32'h10; req_wdata = 32'h12345678; req_valid = 1'b1;
      checkOutput("rst_ready_before", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("rst_wait_no_resp", resp_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready_in_reset", req_ready, 0);
      checkOutput("rst_resp_in_reset", resp_valid, 0);
      reset = 1'b0;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) saw = 1'b1;
      end
      checkOutput("rst_no_resp", saw, 0);
      checkOutput("rst_ready_after", req_ready, 1);
      runAndCheck("lw_after_rst", 1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0);

      // Random traffic over a small window, seeded with known words first.
      win = BASE + 32'h100;
      for (int i = 0; i < 16; i++)
         runAndCheck($sformatf("fill%0d", i), 1'b1, 2'b10, 1'b0, win + 32'(4 * i), $urandom);
      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 9);
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
         else if (r == 1) a = BASE + 32'h2000 + 32'(4 * $urandom_range(0, 3));
         else             a = win + 32'($urandom_range(0, 63));
         runAndCheck($sformatf("rnd%0d", i), ($urandom_range(0, 2) == 0), sz,
                     1'($urandom), a, $urandom);
      end

      // Zero-wait instance with req_valid held high: accept every other cycle.
      @(negedge clk);
      k = 0;
      z_we = z_wr[0]; z_size = z_sz[0]; z_addr = z_ad[0]; z_wdata = z_wd[0];
      z_signed = 1'b0; z_valid = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         checkOutput($sformatf("w0_ready_c%0d", cyc), z_ready, (cyc % 2 == 0));
         checkOutput($sformatf("w0_valid_c%0d", cyc), z_resp_valid, (cyc % 2 == 1));
         if (cyc % 2 == 1) begin
            checkOutput($sformatf("w0_rdata_op%0d", k), z_rdata, z_ex[k]);
            checkOutput($sformatf("w0_err_op%0d", k), z_err, 0);
            k++;
            if (k < 4) begin
               z_we = z_wr[k]; z_size = z_sz[k]; z_addr = z_ad[k]; z_wdata = z_wd[k];
            end else begin
               z_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      checkOutput("w0_idle_after", z_resp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
